// File: rtl/ex.sv
// Execute stage of the 5-stage MIPS pipeline.
// Logic, shift and arithmetic results are combinational. DIV/DIVU run on an
// iterative 32-step restoring divider that holds a stall request until the
// result is ready for HI/LO.
//
// Handshake with pipeline control: while stallreq_o=1 the stage is not
// finished and upstream holds every *_i stable. A non-divide instruction
// completes in the cycle it is presented. A divide completes in the single
// cycle where whilo_o=1; stallreq_o is 0 in that cycle so the instruction
// advances. flush_i kills the instruction in that same cycle.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic [1:0]  div_state
);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t  state, state_next;
  logic [4:0]  cnt;
  logic [31:0] dvs;      // |divisor|
  logic [31:0] quo;      // dividend shifting out, quotient shifting in
  logic [31:0] rem;      // partial remainder
  logic        neg_q;
  logic        neg_r;

  logic [31:0] logic_res, shift_res, arith_res, alu_res;
  logic [31:0] sum, diff;
  logic        ovf;
  logic        is_div, is_signed_div;
  logic        start_busy, start_zero;
  logic [32:0] partial, partial_sub;
  logic        partial_ge;

  assign sum           = reg1_i + reg2_i;
  assign diff          = reg1_i - reg2_i;
  assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed_div = (aluop_i == OP_DIV);

  // Logic-class result
  always_comb begin
    logic_res = 32'd0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = 32'd0;
    endcase
  end

  // Shift-class result: reg2 is the value, reg1[4:0] the amount
  always_comb begin
    shift_res = 32'd0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
      OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
      OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default: shift_res = 32'd0;
    endcase
  end

  // Arithmetic-class result and signed overflow for the trapping forms
  always_comb begin
    arith_res = 32'd0;
    ovf       = 1'b0;
    case (aluop_i)
      OP_ADD: begin
        arith_res = sum;
        ovf       = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
      end
      OP_ADDU: arith_res = sum;
      OP_SUB: begin
        arith_res = diff;
        ovf       = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
      end
      OP_SUBU: arith_res = diff;
      OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
      default: arith_res = 32'd0;
    endcase
  end

  // Write-back data chosen by result class
  always_comb begin
    alu_res = 32'd0;
    case (alusel_i)
      SEL_LOGIC: alu_res = logic_res;
      SEL_SHIFT: alu_res = shift_res;
      SEL_ARITH: alu_res = arith_res;
      default:   alu_res = 32'd0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // rem < dvs always holds, so the 33-bit partial never overflows.
  assign partial     = {rem, quo[31]};
  assign partial_sub = partial - {1'b0, dvs};
  assign partial_ge  = (partial >= {1'b0, dvs});

  assign start_busy = (state == IDLE) && (state_next == BUSY);
  assign start_zero = (state == IDLE) && (state_next == DONE);

  // Divider state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Divider next-state logic; flush always wins
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (is_div) state_next = (reg2_i == 32'd0) ? DONE : BUSY;
      BUSY: if (cnt == 5'd31) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  // Divider datapath: latch operands at start, then step while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 5'd0;
      dvs   <= 32'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start_busy) begin
      cnt   <= 5'd0;
      dvs   <= (is_signed_div && reg2_i[31]) ? -reg2_i : reg2_i;
      quo   <= (is_signed_div && reg1_i[31]) ? -reg1_i : reg1_i;
      rem   <= 32'd0;
      neg_q <= is_signed_div && (reg1_i[31] ^ reg2_i[31]);
      neg_r <= is_signed_div && reg1_i[31];
    end else if (start_zero) begin
      cnt   <= 5'd0;
      dvs   <= 32'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if ((state == BUSY) && !flush_i) begin
      cnt <= cnt + 5'd1;
      quo <= {quo[30:0], partial_ge};
      rem <= partial_ge ? partial_sub[31:0] : partial[31:0];
    end
  end

  // Outputs; everything is held at 0 while reset is asserted
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !ovf;
      wdata_o    = alu_res;
      stallreq_o = !flush_i && (((state == IDLE) && is_div) || (state == BUSY));
      whilo_o    = !flush_i && (state == DONE);
      if (whilo_o) begin
        lo_o = neg_q ? -quo : quo;
        hi_o = neg_r ? -rem : rem;
      end
    end
  end

  assign div_state = state;

endmodule

// File: tb/tb_ex.sv
// Bench for the execute stage: directed ALU vectors and divide scenarios.
// Drivers push expected write-back / HI-LO values; a monitor on the falling
// edge pops and compares whenever the stage completes an instruction.
module tb_ex;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUB  = 8'h22;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] S_NOP = 3'b000;
  localparam logic [2:0] S_LOG = 3'b001;
  localparam logic [2:0] S_SH  = 3'b010;
  localparam logic [2:0] S_AR  = 3'b100;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;
  logic [1:0]  div_state;

  logic [37:0] alu_exp_q[$];   // {wreg, wd, wdata}
  logic [63:0] hilo_exp_q[$];  // {hi, lo}
  logic        alu_valid;
  int          checks;
  int          errors;

  ex dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o),
    .div_state(div_state)
  );

  // Clock and global watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the stage completes in each cycle
  always @(negedge clk) begin
    if (rst) begin
      if (whilo_o) begin
        checks++;
        if (hilo_exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_whilo: got hi=%h lo=%h expected no write", hi_o, lo_o);
        end else begin
          logic [63:0] e;
          e = hilo_exp_q.pop_front();
          if ({hi_o, lo_o} !== e) begin
            errors++;
            $display("FAIL hilo: got hi=%h lo=%h expected hi=%h lo=%h",
                     hi_o, lo_o, e[63:32], e[31:0]);
          end
        end
      end
      if (alu_valid && !stallreq_o) begin
        checks++;
        if (alu_exp_q.size() == 0) begin
          errors++;
          $display("FAIL alu_underflow: got result with no expectation");
        end else begin
          logic [37:0] e;
          e = alu_exp_q.pop_front();
          if ({wreg_o, wd_o, wdata_o} !== e) begin
            errors++;
            $display("FAIL alu: got wreg=%b wd=%0d wdata=%h expected wreg=%b wd=%0d wdata=%h",
                     wreg_o, wd_o, wdata_o, e[37], e[36:32], e[31:0]);
          end
        end
      end
    end
  end

  // Driver: one single-cycle instruction
  task automatic alu_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wd, input logic wr,
                        input logic [31:0] exp_data, input logic exp_wr);
    @(posedge clk); #1;
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b;
    wd_i = wd; wreg_i = wr; flush_i = 1'b0; alu_valid = 1'b1;
    alu_exp_q.push_back({exp_wr, wd, exp_data});
  endtask

  // Driver: one divide, measuring how many cycles it stalls
  task automatic div_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input int exp_stall, input bit disturb);
    int n;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    aluop_i = op; alusel_i = S_NOP; reg1_i = a; reg2_i = b;
    wd_i = 5'd0; wreg_i = 1'b0; flush_i = 1'b0;
    hilo_exp_q.push_back({exp_hi, exp_lo});
    n = 0;
    @(negedge clk);
    while (stallreq_o && n < 100) begin
      n++;
      if (disturb && n == 5) begin
        #1;
        reg1_i = $urandom;
        reg2_i = $urandom_range(1, 32'hFFFF);
      end
      @(negedge clk);
    end
    chk("div_stall_cycles", 64'(n), 64'(exp_stall));
    chk("div_done_whilo", 64'(whilo_o), 64'd1);
  endtask

  task automatic idle_inputs();
    aluop_i = OP_NOP; alusel_i = S_NOP; reg1_i = 32'd0; reg2_i = 32'd0;
    wd_i = 5'd0; wreg_i = 1'b0; flush_i = 1'b0; alu_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();
    aluop_i = OP_ADDU; alusel_i = S_AR; reg1_i = 32'd3; reg2_i = 32'd4;
    wd_i = 5'd5; wreg_i = 1'b1;
    #2;
    chk("reset_outputs", {24'd0, stallreq_o, whilo_o, wreg_o, wd_o, wdata_o}, 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_state", 64'(div_state), 64'd0);
    idle_inputs();
    #10 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_stall", 64'(stallreq_o), 64'd0);

    // Single-cycle operations
    alu_op(OP_ADDU, S_AR, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1, 32'h80000000, 1'b1);
    alu_op(OP_ADD,  S_AR, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1, 32'h80000000, 1'b0);
    alu_op(OP_SUB,  S_AR, 32'h80000000, 32'd1, 5'd6, 1'b1, 32'h7FFFFFFF, 1'b0);
    alu_op(OP_SUBU, S_AR, 32'h80000000, 32'd1, 5'd6, 1'b1, 32'h7FFFFFFF, 1'b1);
    alu_op(OP_ADD,  S_AR, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd9, 1'b1, 32'hFFFFFFFD, 1'b1);
    alu_op(OP_ADDU, S_AR, 32'd1, 32'd2, 5'd7, 1'b0, 32'd3, 1'b0);
    alu_op(OP_SRA,  S_SH, 32'd4, 32'h80000000, 5'd1, 1'b1, 32'hF8000000, 1'b1);
    alu_op(OP_SRL,  S_SH, 32'd4, 32'h80000000, 5'd1, 1'b1, 32'h08000000, 1'b1);
    alu_op(OP_SLL,  S_SH, 32'd31, 32'd1, 5'd2, 1'b1, 32'h80000000, 1'b1);
    alu_op(OP_SLL,  S_SH, 32'h24, 32'd1, 5'd2, 1'b1, 32'h00000010, 1'b1);
    alu_op(OP_NOR,  S_LOG, 32'd0, 32'd0, 5'd3, 1'b1, 32'hFFFFFFFF, 1'b1);
    alu_op(OP_AND,  S_LOG, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 1'b1, 32'hF000F000, 1'b1);
    alu_op(OP_OR,   S_LOG, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 1'b1, 32'hFFF0FFF0, 1'b1);
    alu_op(OP_XOR,  S_LOG, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 1'b1, 32'h0FF00FF0, 1'b1);
    alu_op(OP_SLT,  S_AR, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1, 32'd1, 1'b1);
    alu_op(OP_SLTU, S_AR, 32'hFFFFFFFF, 32'd1, 5'd4, 1'b1, 32'd0, 1'b1);
    alu_op(OP_ADDU, S_NOP, 32'd5, 32'd6, 5'd8, 1'b1, 32'd0, 1'b1);
    alu_op(8'h55,   S_LOG, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 1'b1, 32'd0, 1'b1);
    alu_op(OP_ADDU, S_LOG, 32'd5, 32'd6, 5'd31, 1'b1, 32'd0, 1'b1);

    // Divides, including divide-by-zero and a back-to-back pair
    div_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
    div_op(OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F, 33, 1'b0);
    div_op(OP_DIVU, 32'd100, 32'd0, 32'd0, 32'd0, 1, 1'b0);
    div_op(OP_DIV,  32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 33, 1'b0);
    div_op(OP_DIV,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 33, 1'b0);
    div_op(OP_DIVU, 32'd1000, 32'd7, 32'd142, 32'd6, 33, 1'b1);

    // Flush during BUSY cycle 10
    @(posedge clk); #1;
    alu_valid = 1'b0;
    aluop_i = OP_DIV; alusel_i = S_NOP; reg1_i = 32'hFFFFFFF9; reg2_i = 32'd2; flush_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(stallreq_o), 64'd0);
    chk("flush_whilo", 64'(whilo_o), 64'd0);
    chk("flush_cycle_state", 64'(div_state), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("after_flush_state", 64'(div_state), 64'd0);
    chk("after_flush_stall", 64'(stallreq_o), 64'd0);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    aluop_i = OP_DIV; alusel_i = S_AR; reg1_i = 32'd1000; reg2_i = 32'd3;
    wd_i = 5'd12; wreg_i = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_outputs", {24'd0, stallreq_o, whilo_o, wreg_o, wd_o, wdata_o}, 64'd0);
    chk("midreset_hilo", {hi_o, lo_o}, 64'd0);
    chk("midreset_state", 64'(div_state), 64'd0);
    repeat (3) @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    div_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 1'b0);

    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("alu_queue_empty", 64'(alu_exp_q.size()), 64'd0);
    chk("hilo_queue_empty", 64'(hilo_exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
